// File: rtl/nbc_pkg.sv
// Shared definitions for the naive-Bayes classifier vector loader.
// Frame geometry, label widths, the timeout label code, the loader FSM
// state type and the pixel binarize helper.
package nbc_pkg;

   localparam int unsigned NUM_PIX   = 784;
   localparam int unsigned PIX_W     = 8;
   localparam int unsigned LABEL_W   = 4;
   localparam int unsigned CNT_W     = 10;
   localparam int unsigned RUN_CNT_W = 14;

   localparam logic [LABEL_W-1:0] LABEL_TIMEOUT = 4'hF;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // A pixel equal to the threshold binarizes to 1.
   function automatic logic binarize(input logic [PIX_W-1:0] pix,
                                     input logic [PIX_W-1:0] thr);
      return (pix >= thr);
   endfunction

endpackage

// File: rtl/nbc_run_timer.sv
// RUN-state watchdog for nbc_vec_loader.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   run       high while the loader is in RUN
//   expired   high on the last permitted RUN cycle (run_cnt = TIMEOUT_CYCLES-1)
module nbc_run_timer
   import nbc_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16384
)
(
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic expired
);

   localparam logic [RUN_CNT_W-1:0] LIMIT = RUN_CNT_W'(TIMEOUT_CYCLES - 1);

   logic [RUN_CNT_W-1:0] run_cnt;

   // Held at zero outside RUN, so it is already clear on RUN entry.
   always_ff @(posedge clk) begin
      if (rst || !run) run_cnt <= '0;
      else             run_cnt <= run_cnt + 1'b1;
   end

   assign expired = run && (run_cnt == LIMIT);

endmodule

// File: rtl/nbc_vec_loader.sv
// Upstream feeder for the naive-Bayes classifier.
// Binarizes a valid/ready pixel stream into a NUM_PIX-bit test vector, holds
// it while the classifier runs (cls_rstn high), then presents the captured
// label on a valid/ready result port.
// Optional feature macro: NBC_LOADER_TIMEOUT_EN (RUN-state watchdog).
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   thresh                       binarize threshold (latched on first pixel)
//   pix_valid/ready/data/last    pixel stream
//   test_vector                  binarized frame to classifier, bit i = pixel i
//   cls_rstn                     classifier active-low reset, high only in RUN
//   cls_label_valid, cls_label   classifier result strobe
//   res_valid/ready/label        result port
//   res_timeout                  result produced by the watchdog
//   frame_err                    1-cycle pulse on a framing error
module nbc_vec_loader
   import nbc_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16384
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic [PIX_W-1:0]   thresh,
   input  logic               pix_valid,
   output logic               pix_ready,
   input  logic [PIX_W-1:0]   pix_data,
   input  logic               pix_last,
   output logic [0:NUM_PIX-1] test_vector,
   output logic               cls_rstn,
   input  logic               cls_label_valid,
   input  logic [LABEL_W-1:0] cls_label,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [LABEL_W-1:0] res_label,
   output logic               res_timeout,
   output logic               frame_err
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PIX - 1);

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (1 << RUN_CNT_W)) begin : g_bad_timeout
      $error("nbc_vec_loader: TIMEOUT_CYCLES out of range");
   end

   state_t           state, state_nx;
   logic [CNT_W-1:0] pix_cnt;
   logic [PIX_W-1:0] thresh_q;
   logic             at_end;
   logic             accept;
   logic             frame_ok;
   logic             frame_bad;
   logic             take_label;
   logic             take_timeout;
   logic             run_active;
   logic             timer_expired;

   assign run_active = (state == RUN);

`ifdef NBC_LOADER_TIMEOUT_EN
   nbc_run_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_run_timer (
      .clk     (clk),
      .rst     (rst),
      .run     (run_active),
      .expired (timer_expired)
   );
`else
   assign timer_expired = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= LOAD;
      else     state <= state_nx;
   end

   // Handshake outputs are gated by rst so they drop during the reset cycle,
   // before the synchronous reset has reached the state register.
   always_comb begin
      state_nx     = state;
      pix_ready    = 1'b0;
      cls_rstn     = 1'b0;
      res_valid    = 1'b0;
      accept       = 1'b0;
      frame_ok     = 1'b0;
      frame_bad    = 1'b0;
      take_label   = 1'b0;
      take_timeout = 1'b0;
      at_end       = (pix_cnt == LAST_IDX);
      unique case (state)
         LOAD: begin
            pix_ready = !rst;
            accept    = pix_valid && !rst;
            if (accept) begin
               if (pix_last != at_end) begin
                  frame_bad = 1'b1;
               end else if (at_end) begin
                  frame_ok = 1'b1;
                  state_nx = RUN;
               end
            end
         end
         RUN: begin
            cls_rstn = !rst;
            // A label arriving on the watchdog's last cycle takes precedence.
            if (cls_label_valid) begin
               take_label = 1'b1;
               state_nx   = DONE;
            end else if (timer_expired) begin
               take_timeout = 1'b1;
               state_nx     = DONE;
            end
         end
         DONE: begin
            res_valid = !rst;
            if (res_ready) state_nx = LOAD;
         end
         default: state_nx = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pix_cnt     <= '0;
         thresh_q    <= '0;
         test_vector <= '0;
         res_label   <= '0;
         res_timeout <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         frame_err <= frame_bad;
         if (accept) begin
            // Pixel 0 compares against the live threshold, which is latched here.
            if (pix_cnt == '0) begin
               thresh_q             <= thresh;
               test_vector[pix_cnt] <= binarize(pix_data, thresh);
            end else begin
               test_vector[pix_cnt] <= binarize(pix_data, thresh_q);
            end
            if (frame_ok || frame_bad) pix_cnt <= '0;
            else                       pix_cnt <= pix_cnt + 1'b1;
         end
         if (take_label) begin
            res_label   <= cls_label;
            res_timeout <= 1'b0;
         end else if (take_timeout) begin
            res_label   <= LABEL_TIMEOUT;
            res_timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_nbc_vec_loader.sv
// Self-checking bench for nbc_vec_loader. Expected results are queued when a
// label (or timeout) is provoked and compared on the result handshake.
// Build with NBC_LOADER_TIMEOUT_EN to include the watchdog scenarios.
module tb_nbc_vec_loader;
   import nbc_pkg::*;

   logic               clk = 1'b0;
   logic               rst;
   logic [PIX_W-1:0]   thresh;
   logic               pix_valid;
   logic               pix_ready;
   logic [PIX_W-1:0]   pix_data;
   logic               pix_last;
   logic [0:NUM_PIX-1] test_vector;
   logic               cls_rstn;
   logic               cls_label_valid;
   logic [LABEL_W-1:0] cls_label;
   logic               res_valid;
   logic               res_ready;
   logic [LABEL_W-1:0] res_label;
   logic               res_timeout;
   logic               frame_err;

   typedef struct {
      logic [LABEL_W-1:0] label;
      logic               to;
   } res_t;

   res_t               exp_q[$];
   logic [0:NUM_PIX-1] exp_tv;
   int                 n_checks = 0;
   int                 n_errors = 0;

   nbc_vec_loader #(.TIMEOUT_CYCLES(100)) dut (
      .clk             (clk),
      .rst             (rst),
      .thresh          (thresh),
      .pix_valid       (pix_valid),
      .pix_ready       (pix_ready),
      .pix_data        (pix_data),
      .pix_last        (pix_last),
      .test_vector     (test_vector),
      .cls_rstn        (cls_rstn),
      .cls_label_valid (cls_label_valid),
      .cls_label       (cls_label),
      .res_valid       (res_valid),
      .res_ready       (res_ready),
      .res_label       (res_label),
      .res_timeout     (res_timeout),
      .frame_err       (frame_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard: compare on every accepted result.
   always @(negedge clk) begin
      if (!rst && res_valid && res_ready) begin
         if (exp_q.size() == 0) begin
            check("res_q_empty", 32'(exp_q.size()), 32'd1);
         end else begin
            res_t e;
            e = exp_q.pop_front();
            check("res_label", 32'(res_label), 32'(e.label));
            check("res_timeout", 32'(res_timeout), 32'(e.to));
         end
      end
   end

   // mode 0: all val, 1: even 128 / odd 127, 2: random.
   // last_at = index carrying pix_last; NUM_PIX means pix_last never asserted.
   // thresh is inverted after pixel 0 to show mid-frame changes are ignored.
   task automatic send_frame(input int mode, input logic [7:0] val,
                             input logic [7:0] thr, input int last_at);
      int n;
      n = (last_at < NUM_PIX) ? last_at + 1 : NUM_PIX;
      thresh = thr;
      for (int i = 0; i < n; i++) begin
         logic [7:0] p;
         case (mode)
            0:       p = val;
            1:       p = i[0] ? 8'd127 : 8'd128;
            default: p = 8'($urandom_range(0, 255));
         endcase
         pix_valid = 1'b1;
         pix_data  = p;
         pix_last  = (i == last_at);
         exp_tv[i] = (p >= thr);
         if (i == 0)     check("pix_ready_first", 32'(pix_ready), 32'd1);
         if (i == n - 1) check("cls_rstn_pre_last", 32'(cls_rstn), 32'd0);
         @(posedge clk); #1;
         if (i == 0) thresh = ~thr;
      end
      pix_valid = 1'b0;
      pix_last  = 1'b0;
   endtask

   task automatic expect_run();
      check("cls_rstn_run", 32'(cls_rstn), 32'd1);
      check("pix_ready_run", 32'(pix_ready), 32'd0);
      check("tv_diff", 32'($countones(test_vector ^ exp_tv)), 32'd0);
   endtask

   task automatic pulse_label(input logic [LABEL_W-1:0] l, input logic to_exp);
      res_t e;
      e.label = to_exp ? LABEL_TIMEOUT : l;
      e.to    = to_exp;
      exp_q.push_back(e);
      cls_label_valid = 1'b1;
      cls_label       = l;
      @(posedge clk); #1;
      cls_label_valid = 1'b0;
      check("res_valid_after_label", 32'(res_valid), 32'd1);
      check("cls_rstn_done", 32'(cls_rstn), 32'd0);
   endtask

   task automatic finish_result();
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      check("pix_ready_after_hs", 32'(pix_ready), 32'd1);
      check("res_valid_after_hs", 32'(res_valid), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "bench timeout");
   end

   initial begin
      int n;
      rst = 1'b1; thresh = '0; pix_valid = 1'b0; pix_data = '0; pix_last = 1'b0;
      cls_label_valid = 1'b0; cls_label = '0; res_ready = 1'b0; exp_tv = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_pix_ready", 32'(pix_ready), 32'd0);
      check("rst_cls_rstn", 32'(cls_rstn), 32'd0);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_label", 32'(res_label), 32'd0);
      check("rst_res_timeout", 32'(res_timeout), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      check("rst_tv", 32'($countones(test_vector)), 32'd0);
      rst = 1'b0;
      #1;
      check("pix_ready_post_rst", 32'(pix_ready), 32'd1);
      @(posedge clk); #1;

      // 1: all pixels above threshold
      send_frame(0, 8'd200, 8'd128, NUM_PIX - 1);
      expect_run();
      check("tv_all_ones", 32'($countones(test_vector)), 32'(NUM_PIX));
      // pixels offered in RUN must be back-pressured
      pix_valid = 1'b1; pix_data = 8'd0; pix_last = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      pix_valid = 1'b0; pix_last = 1'b0;
      expect_run();
      pulse_label(4'd3, 1'b0);
      finish_result();

      // 2 + 3: equality boundary, label held under back-pressure
      send_frame(1, 8'd0, 8'd128, NUM_PIX - 1);
      expect_run();
      check("tv_even_count", 32'($countones(test_vector)), 32'(NUM_PIX / 2));
      check("tv_bit0", 32'(test_vector[0]), 32'd1);
      check("tv_bit1", 32'(test_vector[1]), 32'd0);
      pulse_label(4'd7, 1'b0);
      for (int k = 0; k < 5; k++) begin
         check("hold_res_valid", 32'(res_valid), 32'd1);
         check("hold_res_label", 32'(res_label), 32'd7);
         check("hold_pix_ready", 32'(pix_ready), 32'd0);
         @(posedge clk); #1;
      end
      finish_result();

      // 4: early pix_last on pixel #500, then a clean frame
      send_frame(2, 8'd0, 8'd90, 499);
      check("err_early_pulse", 32'(frame_err), 32'd1);
      check("err_early_cls_rstn", 32'(cls_rstn), 32'd0);
      check("err_early_pix_ready", 32'(pix_ready), 32'd1);
      @(posedge clk); #1;
      check("err_early_single", 32'(frame_err), 32'd0);
      check("err_early_cls_rstn2", 32'(cls_rstn), 32'd0);
      send_frame(2, 8'd0, 8'd100, NUM_PIX - 1);
      expect_run();
      pulse_label(4'd9, 1'b0);
      finish_result();

      // missing pix_last on the final pixel
      send_frame(2, 8'd0, 8'd60, NUM_PIX);
      check("err_late_pulse", 32'(frame_err), 32'd1);
      check("err_late_cls_rstn", 32'(cls_rstn), 32'd0);
      @(posedge clk); #1;
      check("err_late_single", 32'(frame_err), 32'd0);
      send_frame(0, 8'd10, 8'd11, NUM_PIX - 1);
      expect_run();
      check("tv_all_zero", 32'($countones(test_vector)), 32'd0);

      // 5: reset during RUN discards the frame
      rst = 1'b1;
      #1;
      check("rst_run_cls_rstn", 32'(cls_rstn), 32'd0);
      check("rst_run_pix_ready", 32'(pix_ready), 32'd0);
      check("rst_run_res_valid", 32'(res_valid), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("rst_run_pix_ready_after", 32'(pix_ready), 32'd1);
      check("rst_run_cls_rstn_after", 32'(cls_rstn), 32'd0);
      // label strobe in LOAD is ignored
      cls_label_valid = 1'b1; cls_label = 4'd2;
      @(posedge clk); #1;
      cls_label_valid = 1'b0;
      check("stale_label_res_valid", 32'(res_valid), 32'd0);
      check("stale_label_pix_ready", 32'(pix_ready), 32'd1);

`ifdef NBC_LOADER_TIMEOUT_EN
      // 6: watchdog fires 100 cycles after RUN entry
      send_frame(0, 8'd50, 8'd10, NUM_PIX - 1);
      expect_run();
      begin
         res_t e;
         e.label = LABEL_TIMEOUT;
         e.to    = 1'b1;
         exp_q.push_back(e);
      end
      n = 0;
      while (!res_valid && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("timeout_latency", 32'(n), 32'd100);
      check("timeout_label", 32'(res_label), 32'(LABEL_TIMEOUT));
      check("timeout_flag", 32'(res_timeout), 32'd1);
      finish_result();
      // label on the last permitted cycle beats the watchdog
      send_frame(0, 8'd50, 8'd10, NUM_PIX - 1);
      repeat (99) @(posedge clk);
      #1;
      check("race_cls_rstn", 32'(cls_rstn), 32'd1);
      pulse_label(4'd5, 1'b0);
      check("race_flag", 32'(res_timeout), 32'd0);
      finish_result();
`else
      // without the watchdog RUN waits indefinitely
      send_frame(0, 8'd50, 8'd10, NUM_PIX - 1);
      n = 0;
      while (!res_valid && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      check("no_timeout_wait", 32'(n), 32'd300);
      check("no_timeout_cls_rstn", 32'(cls_rstn), 32'd1);
      pulse_label(4'd5, 1'b0);
      finish_result();
`endif

      repeat (2) @(posedge clk);
      #1;
      check("res_q_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
